// File: rtl/alu_seq_muldiv_if.sv
// Handshake bundle for alu_seq_muldiv; ALU_OVERFLOW_EN adds the ovf flag.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CTL_W-1:0] alu_ctl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
`ifdef ALU_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, alu_ctl, input busy, done, result, hi, zero, ovf);
  modport slave  (input start, a, b, alu_ctl, output busy, done, result, hi, zero, ovf);
`else
  modport master (output start, a, b, alu_ctl, input busy, done, result, hi, zero);
  modport slave  (input start, a, b, alu_ctl, output busy, done, result, hi, zero);
`endif
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered MIPS ALU with iterative MULTU/DIVU; 1 cycle simple ops, WIDTH+1 for mul/div.
// start ignored while busy or in the done cycle; ALU_OVERFLOW_EN adds signed-overflow flag ovf.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_muldiv_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CTL_W-1:0] OP_AND   = CTL_W'(4'b0000);
  localparam logic [CTL_W-1:0] OP_OR    = CTL_W'(4'b0001);
  localparam logic [CTL_W-1:0] OP_ADD   = CTL_W'(4'b0010);
  localparam logic [CTL_W-1:0] OP_SUB   = CTL_W'(4'b0110);
  localparam logic [CTL_W-1:0] OP_SLT   = CTL_W'(4'b0111);
  localparam logic [CTL_W-1:0] OP_SLTU  = CTL_W'(4'b1000);
  localparam logic [CTL_W-1:0] OP_NOR   = CTL_W'(4'b1100);
  localparam logic [CTL_W-1:0] OP_MULTU = CTL_W'(4'b1001);
  localparam logic [CTL_W-1:0] OP_DIVU  = CTL_W'(4'b1010);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q;
  logic             busy_c, done_c, last;
  logic [WIDTH-1:0] alu_res, sum, diff;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.alu_ctl == OP_MULTU)                     state_nxt = MUL;
          else if (bus.alu_ctl == OP_DIVU && bus.b != '0)  state_nxt = DIV;
          else                                             state_nxt = DONE;
        end
      end
      MUL, DIV: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    alu_res = '0;
    case (bus.alu_ctl)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      default: alu_res = '0;
    endcase
  end

  // Shift-add: the carry out of the partial sum becomes the new top bit of HI.
  assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Restoring division: acc_hi holds the partial remainder, acc_lo shifts dividend out / quotient in.
  assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, opnd};
  assign div_hi_nxt = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_lo_nxt = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};

`ifdef ALU_OVERFLOW_EN
  logic ovf_q, alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    if (bus.alu_ctl == OP_ADD)
      alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    else if (bus.alu_ctl == OP_SUB)
      alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (state == IDLE && bus.start) ovf_q <= alu_ovf;
    else if ((state == MUL || state == DIV) && last) ovf_q <= 1'b0;
  end

  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            acc_hi <= '0;
            if (bus.alu_ctl == OP_MULTU) begin
              opnd   <= bus.a;
              acc_lo <= bus.b;
            end else if (bus.alu_ctl == OP_DIVU) begin
              opnd   <= bus.b;
              acc_lo <= bus.a;
              if (bus.b == '0) begin
                result_q <= '1;
                hi_q     <= bus.a;
                zero_q   <= 1'b0;
              end
            end else begin
              result_q <= alu_res;
              hi_q     <= '0;
              zero_q   <= (alu_res == '0);
            end
          end
        end
        MUL: begin
          cnt    <= cnt + CNT_W'(1);
          acc_hi <= mul_hi_nxt;
          acc_lo <= mul_lo_nxt;
          if (last) begin
            result_q <= mul_lo_nxt;
            hi_q     <= mul_hi_nxt;
            zero_q   <= (mul_lo_nxt == '0);
          end
        end
        DIV: begin
          cnt    <= cnt + CNT_W'(1);
          acc_hi <= div_hi_nxt;
          acc_lo <= div_lo_nxt;
          if (last) begin
            result_q <= div_lo_nxt;
            hi_q     <= div_hi_nxt;
            zero_q   <= (div_lo_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;
  assign bus.hi     = hi_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv (WIDTH=32); define ALU_OVERFLOW_EN to also check ovf.
module tb_alu_seq_muldiv;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1000,
                         OP_NOR = 4'b1100, OP_MULTU = 4'b1001, OP_DIVU = 4'b1010;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    int          lat;
    int          issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  alu_seq_muldiv_if #(.WIDTH(32), .CTL_W(4)) bus ();

  alu_seq_muldiv #(.WIDTH(32), .CTL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb_, s;
    logic [63:0] p;
    e.res = '0; e.hi = '0; e.ovf = 1'b0; e.lat = 1; e.issue = 0;
    sa = $signed(a);
    sb_ = $signed(b);
    case (op)
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_ADD:  begin e.res = a + b; s = sa + sb_; e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      OP_SUB:  begin e.res = a - b; s = sa - sb_; e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      OP_SLT:  e.res = (sa < sb_) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      OP_NOR:  e.res = ~(a | b);
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      OP_DIVU: begin
        if (b == 0) begin e.res = 32'hFFFFFFFF; e.hi = a; end
        else begin e.res = a / b; e.hi = a % b; e.lat = 33; end
      end
      default: ;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Drive one request; start held for 'hold' edges, operands scrambled afterwards.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int hold, input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.alu_ctl = op; bus.a = a; bus.b = b;
    e = model(op, a, b);
    e.issue = cyc;
    if (expect_done) sb.push_back(e);
    repeat (hold) @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.alu_ctl = 4'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("result", 64'(bus.result), 64'(e.res));
        check_val("hi", 64'(bus.hi), 64'(e.hi));
        check_val("zero", 64'(bus.zero), 64'(e.zero));
        check_val("latency", 64'(cyc - e.issue), 64'(e.lat));
        check_val("busy_in_done", 64'(bus.busy), 64'd0);
`ifdef ALU_OVERFLOW_EN
        check_val("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
      end
    end
  end

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_val({tag, "_done"}, 64'(bus.done), 64'd0);
    check_val({tag, "_result"}, 64'(bus.result), 64'd0);
    check_val({tag, "_hi"}, 64'(bus.hi), 64'd0);
    check_val({tag, "_zero"}, 64'(bus.zero), 64'd1);
`ifdef ALU_OVERFLOW_EN
    check_val({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
`endif
  endtask

  initial begin
    logic [3:0] ops [10];
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_NOR, OP_MULTU, OP_DIVU, 4'b0011};
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_ctl = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    send(OP_ADD, 32'hFFFFFFFF, 32'd1, 1, 1'b1); wait_done();
    send(OP_SUB, 32'd5, 32'd7, 1, 1'b1);        wait_done();
    send(OP_SLT, 32'hFFFFFFFF, 32'd1, 1, 1'b1); wait_done();
    send(OP_SLTU, 32'hFFFFFFFF, 32'd1, 1, 1'b1); wait_done();
    send(OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 1, 1'b1); wait_done();
    send(OP_NOR, 32'h0, 32'h0, 1, 1'b1);        wait_done();
    send(OP_ADD, 32'h7FFFFFFF, 32'd1, 1, 1'b1); wait_done();
    send(OP_SUB, 32'h80000000, 32'd1, 1, 1'b1); wait_done();

    // MULTU with a start pulse mid-operation that must be ignored.
    send(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1, 1'b1);
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1; bus.alu_ctl = OP_ADD; bus.a = 32'd1; bus.b = 32'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done();

    send(OP_DIVU, 32'd100, 32'd7, 1, 1'b1); wait_done();
    send(OP_DIVU, 32'd9, 32'd0, 1, 1'b1);   wait_done();
    send(OP_DIVU, 32'd3, 32'd10, 1, 1'b1);  wait_done();

    // start held through the DONE cycle must not issue a second operation.
    send(OP_OR, 32'h0000_00F0, 32'h0000_000F, 2, 1'b1);
    repeat (3) @(negedge clk);

    // Reset during MULTU aborts with no done pulse.
    send(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_state("abort");
    send(OP_ADD, 32'd2, 32'd3, 1, 1'b1); wait_done();
    repeat (40) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(ops[$urandom_range(0, 9)], $urandom, (i % 4 == 3) ? 32'd0 : $urandom, 1, 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
